// File: rtl/min_max_pkg.sv
// Shared definitions for the min/max LED bar display.
// Contents:
//   com_t        display mode carried on com_i (RANGE, THERMO, OFF, ON)
//   leds_width   LED vector width for a given value width (2**valsize)
//   cnt_width    register width able to hold 0..n-1 (at least 1 bit)
package min_max_pkg;

   typedef enum logic [1:0] {
      RANGE  = 2'b00,
      THERMO = 2'b01,
      OFF    = 2'b10,
      ON     = 2'b11
   } com_t;

   function automatic int unsigned leds_width(input int unsigned valsize);
      return 32'd1 << valsize;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/min_max_blink.sv
// Free-running blink generator: counts 0..BLINK_DIV-1 and toggles osc_o on
// every wrap, giving a square wave of period 2*BLINK_DIV clock cycles.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset (counter 0, osc_o 0)
//   osc_o  registered blink signal
module min_max_blink
   import min_max_pkg::*;
#(
   parameter int unsigned BLINK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic osc_o
);

   localparam int unsigned   CW       = cnt_width(BLINK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt   <= '0;
         osc_o <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt   <= '0;
         osc_o <= ~osc_o;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/min_max_seq.sv
// LED bar display of a sampled value with a decaying peak marker.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   com_i        display mode (see min_max_pkg::com_t)
//   min_i/max_i  window bounds for RANGE mode
//   val_i        sample, captured when val_valid_i is high
//   val_valid_i  sample qualifier
//   leds_o       registered LED vector, 2**VALSIZE bits
//   peak_o       held peak value (decays one step every PEAK_HOLD cycles)
//   osc_o        blink signal used for the unlit part of the range bar
module min_max_seq
   import min_max_pkg::*;
#(
   parameter int unsigned VALSIZE   = 4,
   parameter int unsigned BLINK_DIV = 4,
   parameter int unsigned PEAK_HOLD = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [1:0]            com_i,
   input  logic [VALSIZE-1:0]    min_i,
   input  logic [VALSIZE-1:0]    max_i,
   input  logic [VALSIZE-1:0]    val_i,
   input  logic                  val_valid_i,
   output logic [2**VALSIZE-1:0] leds_o,
   output logic [VALSIZE-1:0]    peak_o,
   output logic                  osc_o
);

   localparam int unsigned   NLEDS     = leds_width(VALSIZE);
   localparam int unsigned   HW        = cnt_width(PEAK_HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'(PEAK_HOLD - 1);

   logic [VALSIZE-1:0] val_q;
   logic [VALSIZE-1:0] peak_q;
   logic [HW-1:0]      hold;
   logic [NLEDS-1:0]   leds_d;
   logic               val_in;
   logic               peak_in;

   min_max_blink #(
      .BLINK_DIV(BLINK_DIV)
   ) u_blink (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .osc_o(osc_o)
   );

   // A new sample at or above the peak wins over a coinciding decay step.
   // Decay never drops below the current sample, so peak_q >= val_q holds.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         val_q  <= '0;
         peak_q <= '0;
         hold   <= HOLD_LAST;
         leds_o <= '0;
      end else begin
         leds_o <= leds_d;
         if (val_valid_i) begin
            val_q <= val_i;
         end
         if (val_valid_i && (val_i >= peak_q)) begin
            peak_q <= val_i;
            hold   <= HOLD_LAST;
         end else if (hold == '0) begin
            hold <= HOLD_LAST;
            if (peak_q > val_q) begin
               peak_q <= peak_q - VALSIZE'(1);
            end
         end else begin
            hold <= hold - HW'(1);
         end
      end
   end

   assign peak_o  = peak_q;
   assign val_in  = (val_q >= min_i) && (val_q <= max_i);
   assign peak_in = (peak_q >= min_i) && (peak_q <= max_i);

   always_comb begin
      leds_d = '0;
      unique case (com_t'(com_i))
         RANGE: begin
            // val_in already implies min_i <= max_i
            if (val_in) begin
               for (int unsigned i = 0; i < NLEDS; i++) begin
                  if ((i >= 32'(min_i)) && (i <= 32'(max_i))) begin
                     leds_d[VALSIZE'(i)] = (i <= 32'(val_q)) ? 1'b1 : osc_o;
                  end
               end
               if (peak_in) begin
                  leds_d[peak_q] = 1'b1;
               end
            end
         end
         THERMO: begin
            for (int unsigned i = 0; i < NLEDS; i++) begin
               leds_d[VALSIZE'(i)] = (i <= 32'(val_q));
            end
         end
         OFF:     leds_d = '0;
         ON:      leds_d = '1;
         default: leds_d = '0;
      endcase
   end

endmodule
